texture_arbiter: RTL



---
 rtl/texture_arb_pkg.sv | 30 +++
 rtl/write_strobe_seq.sv | 106 ++++++++++
 rtl/texture_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/texture_arb_pkg.sv
// Shared types and constants for the texture BRAM arbiter.
package texture_arb_pkg;

  // Host write sequencer states
  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    W_DONE
  } wstate_t;

  // Default geometry of the texture store
  localparam int DEF_ADDR_W        = 13;
  localparam int DEF_BANKS         = 8;
  localparam int DEF_WDATA_W       = 8;
  localparam int DEF_RDATA_W       = 4;
  localparam int DEF_RD_LAT        = 2;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 2;

  // Address bits that pick the BRAM tile
  localparam int BANK_LSB = 10;
  localparam int BANK_MSB = 12;
  localparam int BANK_W   = BANK_MSB - BANK_LSB + 1;

  // Width of the setup/strobe/hold cycle counter
  localparam int CNT_W = 8;

endpackage

// File: rtl/write_strobe_seq.sv
// Host write sequencer: latches one write, then drives setup, a one-hot
// per-bank strobe, hold and a completion pulse, all from registers.
module write_strobe_seq
  import texture_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int BANKS         = DEF_BANKS,
  parameter int WDATA_W       = DEF_WDATA_W,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int WR_BLANK_ONLY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vid_active,
  input  logic               hw_valid,
  output logic               hw_ready,
  input  logic [ADDR_W-1:0]  hw_addr,
  input  logic [WDATA_W-1:0] hw_data,
  output logic               hw_done,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WDATA_W-1:0] mem_wdata,
  output logic [BANKS-1:0]   mem_wstrobe,
  output logic               busy
);

  wstate_t            state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [ADDR_W-1:0]  waddr_reg;
  logic [WDATA_W-1:0] wdata_reg;
  logic [BANKS-1:0]   wstrobe_reg;
  logic               done_reg;
  logic [BANKS-1:0]   bank_hot;
  logic               blank_gate;

  // One-hot tile select from the latched address
  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank_dec
      assign bank_hot[gi] = (waddr_reg[BANK_MSB:BANK_LSB] == BANK_W'(gi));
    end
  endgenerate

  assign blank_gate = (WR_BLANK_ONLY != 0) && vid_active;
  assign hw_ready   = (state_reg == W_IDLE) && !blank_gate;

  // Write FSM with registered strobe, done pulse and latched address/data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= W_IDLE;
      cnt_reg     <= '0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
      wstrobe_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        W_IDLE: begin
          if (hw_valid && !blank_gate) begin
            waddr_reg <= hw_addr;
            wdata_reg <= hw_data;
            state_reg <= W_SETUP;
          end
        end
        W_SETUP: begin
          state_reg   <= W_STROBE;
          cnt_reg     <= CNT_W'(STROBE_CYCLES - 1);
          wstrobe_reg <= bank_hot;
        end
        W_STROBE: begin
          if (cnt_reg == '0) begin
            state_reg   <= W_HOLD;
            cnt_reg     <= CNT_W'(HOLD_CYCLES - 1);
            wstrobe_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        W_HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= W_DONE;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        W_DONE: begin
          state_reg <= W_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg   <= W_IDLE;
          wstrobe_reg <= '0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_waddr   = waddr_reg;
  assign mem_wdata   = wdata_reg;
  assign mem_wstrobe = wstrobe_reg;
  assign hw_done     = done_reg;
  assign busy        = (state_reg != W_IDLE);

endmodule

// File: rtl/texture_arbiter.sv
// Texture BRAM arbiter: video owns the read port while active, host reads
// fill blanking, host writes go through the strobe sequencer.
module texture_arbiter
  import texture_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int BANKS         = DEF_BANKS,
  parameter int WDATA_W       = DEF_WDATA_W,
  parameter int RDATA_W       = DEF_RDATA_W,
  parameter int RD_LAT        = DEF_RD_LAT,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int WR_BLANK_ONLY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vid_active,
  input  logic [ADDR_W-1:0]  vid_raddr,
  output logic [RDATA_W-1:0] vid_rdata,
  input  logic               hr_valid,
  output logic               hr_ready,
  input  logic [ADDR_W-1:0]  hr_addr,
  output logic               hr_rvalid,
  output logic [RDATA_W-1:0] hr_rdata,
  input  logic               hw_valid,
  output logic               hw_ready,
  input  logic [ADDR_W-1:0]  hw_addr,
  input  logic [WDATA_W-1:0] hw_data,
  output logic               hw_done,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [RDATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WDATA_W-1:0] mem_wdata,
  output logic [BANKS-1:0]   mem_wstrobe,
  output logic               busy
);

  logic [RD_LAT-1:0] rd_pipe_reg;
  logic              hr_accept;
  logic              wr_busy;

  assign mem_raddr = vid_active ? vid_raddr : hr_addr;
  assign vid_rdata = mem_rdata;
  assign hr_ready  = !vid_active;
  assign hr_accept = hr_valid && !vid_active;

  // Track accepted host reads through the memory latency; never cancelled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe_reg <= '0;
    end else begin
      rd_pipe_reg[0] <= hr_accept;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_reg[i] <= rd_pipe_reg[i-1];
      end
    end
  end

  assign hr_rvalid = rd_pipe_reg[RD_LAT-1];
  assign hr_rdata  = hr_rvalid ? mem_rdata : '0;
  assign busy      = wr_busy || (|rd_pipe_reg);

  write_strobe_seq #(
    .ADDR_W        (ADDR_W),
    .BANKS         (BANKS),
    .WDATA_W       (WDATA_W),
    .STROBE_CYCLES (STROBE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .WR_BLANK_ONLY (WR_BLANK_ONLY)
  ) u_wseq (
    .clk         (clk),
    .reset_n     (reset_n),
    .vid_active  (vid_active),
    .hw_valid    (hw_valid),
    .hw_ready    (hw_ready),
    .hw_addr     (hw_addr),
    .hw_data     (hw_data),
    .hw_done     (hw_done),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wstrobe (mem_wstrobe),
    .busy        (wr_busy)
  );

endmodule
